// File: rtl/dec_arb_pkg.sv
// Shared definitions for the decrementer-sharing arbiter: state encoding,
// default sizes and the round-robin winner search.
package dec_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_NREQ  = 8;

  // Rotate req so bit ptr lands at 0, take the first set bit, then undo the rotation.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                         input logic [MAX_NREQ-1:0] req,
                                         input int nreq);
    logic [MAX_NREQ-1:0] rot;
    logic [2:0]          win;
    logic                found;
    rot   = '0;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < nreq) rot[k] = req[(int'(ptr) + k) % nreq];
    end
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = 3'((int'(ptr) + k) % nreq);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dec_share_arb_if.sv
// Requester/response bundle of the shared decrementer arbiter.
interface dec_share_arb_if
  import dec_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_bout;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req, req_data, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_bout, busy
  );

  modport slave (
    input  req, req_data, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_bout, busy
  );
endinterface

// File: rtl/dec.sv
// Combinational decrementer: OUT = IN - 1 modulo 2^WIDTH, Bout set when IN was 0.
module dec #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             Bout
);
  // The extra top bit of the widened difference is the borrow.
  assign {Bout, OUT} = {1'b0, IN} - (WIDTH+1)'(1);
endmodule

// File: rtl/dec_share_arb.sv
// Round-robin arbiter that time-shares one dec unit among NREQ requesters,
// one operation per IDLE -> CALC -> RESP pass.
module dec_share_arb
  import dec_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst,
  dec_share_arb_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, id_q, pick;
  logic [WIDTH-1:0] op_q, res_q, dec_out;
  logic [NREQ-1:0]  gnt_q;
  logic             bout_q, dec_bout, any_req;

  assign any_req = |bus.req;
  assign pick    = IDW'(rr_pick(3'(ptr), MAX_NREQ'(bus.req), NREQ));

  dec #(.WIDTH(WIDTH)) u_dec (
    .IN   (op_q),
    .OUT  (dec_out),
    .Bout (dec_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ptr only advances on response acceptance, so re-requests queue behind others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      op_q   <= '0;
      gnt_q  <= '0;
      id_q   <= '0;
      res_q  <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_q  <= bus.req_data[int'(pick)*WIDTH +: WIDTH];
            gnt_q <= NREQ'(1) << pick;
            id_q  <= pick;
          end
        end
        CALC: begin
          res_q  <= dec_out;
          bout_q <= dec_bout;
          gnt_q  <= '0;
        end
        RESP: begin
          if (bus.rsp_ready)
            ptr <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = res_q;
  assign bus.rsp_bout  = bout_q;

endmodule

// File: tb/tb_dec_share_arb.sv
// Directed bench for dec_share_arb: grant timing, arithmetic boundaries,
// round-robin order, backpressure and asynchronous reset.
module tb_dec_share_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dec_share_arb_if #(.NREQ(4), .WIDTH(32)) bus ();

  dec_share_arb #(.NREQ(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    bus.req_data[i*32 +: 32] = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt),       32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"},    32'(bus.rsp_id),    32'd0);
    chk({tag, "_data"},  bus.rsp_data,       32'd0);
    chk({tag, "_bout"},  32'(bus.rsp_bout),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  // One full pass with rsp_ready high; drop_req clears req right after the grant.
  task automatic do_op(input string tag, input int id, input logic [31:0] res,
                       input logic bout, input logic drop_req);
    tick();
    chk({tag, "_gnt"},   32'(bus.gnt),       32'(4'b0001 << id));
    chk({tag, "_busy"},  32'(bus.busy),      32'd1);
    chk({tag, "_v0"},    32'(bus.rsp_valid), 32'd0);
    if (drop_req) bus.req = '0;
    tick();
    chk({tag, "_gnt1"},  32'(bus.gnt),       32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    chk({tag, "_data"},  bus.rsp_data,       res);
    chk({tag, "_bout"},  32'(bus.rsp_bout),  32'(bout));
    tick();
    chk({tag, "_idle_v"},   32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle_gnt"}, 32'(bus.gnt),       32'd0);
    chk({tag, "_idle_bsy"}, 32'(bus.busy),      32'd0);
    chk({tag, "_ptr"},      32'(dut.ptr),       32'((id + 1) % 4));
  endtask

  initial begin
    bus.req       = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    chk("reset_ptr", 32'(dut.ptr), 32'd0);
    rst = 1'b0;

    bus.rsp_ready = 1'b1;
    set_op(0, 32'd5);
    bus.req = 4'b0001;
    do_op("basic", 0, 32'd4, 1'b0, 1'b1);

    set_op(1, 32'h0000_0000);
    bus.req = 4'b0010;
    do_op("under", 1, 32'hFFFF_FFFF, 1'b1, 1'b1);

    set_op(2, 32'h8000_0000);
    bus.req = 4'b0100;
    do_op("sign", 2, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // ptr is now 3: requester 3 first, then wrap to 0.
    set_op(0, 32'd7);
    set_op(3, 32'd100);
    bus.req = 4'b1001;
    do_op("wrap3", 3, 32'd99, 1'b0, 1'b0);
    do_op("wrap0", 0, 32'd6,  1'b0, 1'b1);

    bus.rsp_ready = 1'b0;
    set_op(1, 32'd50);
    bus.req = 4'b0010;
    tick();
    chk("bp_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    tick();
    chk("bp_valid0", 32'(bus.rsp_valid), 32'd1);
    set_op(2, 32'd60);
    bus.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data",  bus.rsp_data,       32'd49);
      chk("bp_hold_id",    32'(bus.rsp_id),    32'd1);
      chk("bp_hold_gnt",   32'(bus.gnt),       32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_acc_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_acc_gnt",   32'(bus.gnt),       32'd0);
    chk("bp_acc_ptr",   32'(dut.ptr),       32'd2);
    do_op("bp_new", 2, 32'd59, 1'b0, 1'b1);

    set_op(0, 32'd1);
    bus.req = 4'b0001;
    tick();
    chk("rcalc_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_calc");
    chk("rst_calc_ptr", 32'(dut.ptr), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_calc_after", 32'(bus.rsp_valid), 32'd0);

    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    chk("rresp_valid", 32'(bus.rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_resp");
    rst = 1'b0;
    tick();
    chk("rst_resp_after", 32'(bus.rsp_valid), 32'd0);
    chk("rst_resp_busy",  32'(bus.busy),      32'd0);

    set_op(2, 32'd9);
    bus.req = 4'b0100;
    do_op("post_rst", 2, 32'd8, 1'b0, 1'b1);

    rst = 1'b1;
    #1 rst = 1'b0;
    chk("rr_ptr0", 32'(dut.ptr), 32'd0);
    set_op(0, 32'd10);
    set_op(1, 32'd20);
    set_op(2, 32'd30);
    set_op(3, 32'd40);
    bus.req = 4'b1111;
    do_op("rr0", 0, 32'd9,  1'b0, 1'b0);
    do_op("rr1", 1, 32'd19, 1'b0, 1'b0);
    do_op("rr2", 2, 32'd29, 1'b0, 1'b0);
    do_op("rr3", 3, 32'd39, 1'b0, 1'b0);
    do_op("rr4", 0, 32'd9,  1'b0, 1'b1);
    tick();
    chk("end_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_share_arb.md
# dec_share_arb

Round-robin arbiter and sequencer that shares one 32-bit `dec` unit between NREQ requesters, e.g. the stack-pointer, loop-counter and PC-adjust paths of the multi-cycle CPU. Each transaction grants one requester and latches its operand. The single shared decrementer then computes `operand - 1` and the borrow. The result is returned through a valid/ready handshake. This removes per-requester decrementers from the datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand width; must match `dec` (32).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input NREQ: per-requester request level.
- `req_data` input NREQ*WIDTH: packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt` output NREQ: one-hot grant; a 1-cycle pulse when the operand is captured.
- `rsp_valid` output 1: result available.
- `rsp_id` output $clog2(NREQ): index of the requester that owns the result.
- `rsp_data` output WIDTH: `operand - 1`.
- `rsp_bout` output 1: borrow out; 1 only when the operand was 0.
- `rsp_ready` input 1: consumer accepts the result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any `req` bit is set, select the winner round-robin, starting the search at `ptr`.
  - Latch `req_data` of the winner into `op_q`, set `gnt_q` one-hot and `id_q`, then go to CALC.
  - If no `req` bit is set, stay in IDLE.
- CALC:
  - `op_q` drives the `dec` instance combinationally.
  - Register `OUT` into `res_q` and `Bout` into `bout_q`.
  - Clear `gnt_q` and go to RESP.
- RESP:
  - Hold `rsp_valid`=1 with stable `rsp_id`, `rsp_data` and `rsp_bout`.
  - On a clock edge with `rsp_ready`=1, go to IDLE and set `ptr` = (`id_q`+1) mod NREQ.
- Round-robin rule: search order is `ptr`, `ptr`+1, … with wrap-around at NREQ-1 → 0. `ptr` changes only on response acceptance.
- Requester obligation:
  - Hold `req_data` stable while `req` is high.
  - Drop `req` on the cycle after `gnt`, or keep it high to be re-queued.
  - A still-high `req` competes again on the next IDLE cycle at the lowest priority.
- Width rule: modulo 2^WIDTH arithmetic.
  - 0x00000000 → 0xFFFFFFFF with `rsp_bout`=1.
  - 0x80000000 → 0x7FFFFFFF with `rsp_bout`=0.
- Request changes outside IDLE are ignored; no preemption.
- Reset:
  - Asynchronous; may occur in any state.
  - Forces IDLE and sets `ptr`=0.
  - Clears `gnt`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_bout` and `busy` to 0.
  - Any in-flight operation is discarded with no response.

## Timing
- Edge k: IDLE samples `req` with at least one bit set. `gnt` is high for exactly the cycle k→k+1, and `busy` rises.
- Edge k+1: `rsp_valid` rises.
- Earliest acceptance is edge k+2 with `rsp_ready`=1, giving IDLE in cycle k+2→k+3.
- Back-to-back throughput: one operation per 3 cycles when `rsp_ready` is tied high.
- All outputs are registered; there is no combinational path from `req` or `rsp_ready` to any output.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.

## Structure
- Shared package `dec_arb_pkg` holds:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, RESP=2'd2;
  - default `NREQ` and `WIDTH`;
  - a round-robin pick function (ptr, req) → index.
- One sub-module: the existing `dec` unit, instantiated once; no subtraction logic is duplicated.
- Round-robin selection is combinational inside the block: the request vector is rotated by `ptr`, the first set bit is chosen, and the result is un-rotated.
- Registers: `state`, `ptr`, `op_q`, `gnt_q`, `id_q`, `res_q`, `bout_q`.

## Test plan
- Reset, then `req`=0001 with operand 5, `rsp_ready`=1:
  - `gnt`=0001 for 1 cycle;
  - `rsp_valid` one cycle later with `rsp_id`=0, `rsp_data`=4, `rsp_bout`=0;
  - `ptr` becomes 1.
- Underflow: operand 0x00000000 → `rsp_data`=0xFFFFFFFF, `rsp_bout`=1. Sign boundary: operand 0x80000000 → `rsp_data`=0x7FFFFFFF, `rsp_bout`=0.
- All four `req` held high with operands 10, 20, 30, 40 and `rsp_ready`=1:
  - grant order 0,1,2,3,0;
  - results 9, 19, 29, 39;
  - one grant every 3 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid` and `rsp_data` stay stable and no new `gnt` is issued.
  - A new `req` arriving meanwhile is granted only after acceptance.
- With `ptr`=3 (after serving requester 2), `req`=1001: requester 3 is granted first, then requester 0 (wrap-around).
- Assert `rst` asynchronously in CALC and again in RESP:
  - all outputs are 0 immediately, without waiting for a clock edge;
  - the next `req`=0100 is granted to requester 2 with a search starting at `ptr`=0;
  - the discarded operation never produces `rsp_valid`.
